ex_operand_stage: RTL and testbench

- ID/EX pipeline register plus the EX-stage operand network that drives the ALU's `a`, `b`, `oper` and `sign` inputs.
- Captures decoded instructions from ID and resolves RAW hazards by forwarding from MEM and WB.
- Detects load-use hazards and inserts bubbles. Passes write-back and memory control downstream to EX/MEM.

---
 rtl/ex_operand_stage_pkg.sv | 28 ++
 rtl/ex_operand_stage_fwd_mux.sv | 34 +++
 rtl/ex_operand_stage.sv | 187 ++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_operand_stage_pkg.sv
// Shared definitions for the EX operand stage.
//   EXE_ALU_*  : ALU operation codes understood by the downstream ALU.
//   A_* / B_*  : operand-select codes carried from decode into EX.
//   sel_t      : 2-bit operand-select type (code 3 is legal and selects zero).
package ex_operand_stage_pkg;

    localparam logic [3:0] EXE_ALU_AND = 4'd0;
    localparam logic [3:0] EXE_ALU_OR  = 4'd1;
    localparam logic [3:0] EXE_ALU_ADD = 4'd2;
    localparam logic [3:0] EXE_ALU_XOR = 4'd3;
    localparam logic [3:0] EXE_ALU_NOR = 4'd4;
    localparam logic [3:0] EXE_ALU_SUB = 4'd6;
    localparam logic [3:0] EXE_ALU_SLT = 4'd7;
    localparam logic [3:0] EXE_ALU_SLL = 4'd8;
    localparam logic [3:0] EXE_ALU_SRL = 4'd9;
    localparam logic [3:0] EXE_ALU_SRA = 4'd10;

    typedef logic [1:0] sel_t;

    localparam sel_t A_RS    = 2'd0;
    localparam sel_t A_SHAMT = 2'd1;
    localparam sel_t A_PC    = 2'd2;

    localparam sel_t B_RT    = 2'd0;
    localparam sel_t B_IMM   = 2'd1;
    localparam sel_t B_EIGHT = 2'd2;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Forwarding selector for one EX source operand.
//   addr            : source register address held in EX
//   reg_val         : value captured into EX (register file or ID bypass)
//   mem_*           : EX/MEM producer (loads cannot forward from here)
//   wb_*            : MEM/WB producer
//   val             : resolved operand value
// Register $0 always reads as zero, which also keeps writes to $0 from forwarding.
module fwd_mux #(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] addr,
    input  logic [31:0]     reg_val,
    input  logic            mem_wb_en,
    input  logic            mem_is_load,
    input  logic [RA_W-1:0] mem_wb_addr,
    input  logic [31:0]     mem_alu_result,
    input  logic            wb_en,
    input  logic [RA_W-1:0] wb_addr,
    input  logic [31:0]     wb_data,
    output logic [31:0]     val
);

    always_comb begin
        val = reg_val;
        if (addr == '0) begin
            val = '0;
        end else if (mem_wb_en && !mem_is_load && (mem_wb_addr == addr)) begin
            val = mem_alu_result;
        end else if (wb_en && (wb_addr == addr)) begin
            val = wb_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and EX operand network.
//   clk, rst                 : pipeline clock, async active-high reset
//   ex_stall, id_flush       : hold EX / replace ID instruction with a bubble
//   id_*                     : decoded instruction from ID
//   mem_*, wb_*              : forwarding sources (EX/MEM and MEM/WB)
//   alu_a/b/oper/sign        : ALU inputs
//   ex_*                     : registered EX control passed on to EX/MEM
//   ex_store_data            : forwarded rt value for stores
//   load_use_stall           : freeze PC/IF/ID for one cycle on load-use
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int         RA_W        = 5,
    parameter logic [3:0] BUBBLE_OPER = EXE_ALU_ADD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_stall,
    input  logic            id_flush,
    input  logic            id_valid,
    input  logic [31:0]     id_pc,
    input  logic [RA_W-1:0] id_rs_addr,
    input  logic [RA_W-1:0] id_rt_addr,
    input  logic [31:0]     id_rs_data,
    input  logic [31:0]     id_rt_data,
    input  logic [31:0]     id_imm,
    input  logic [4:0]      id_shamt,
    input  logic [3:0]      id_alu_oper,
    input  logic            id_alu_sign,
    input  logic [1:0]      id_a_sel,
    input  logic [1:0]      id_b_sel,
    input  logic            id_wb_en,
    input  logic [RA_W-1:0] id_wb_addr,
    input  logic            id_mem_r,
    input  logic            id_mem_w,
    input  logic            mem_wb_en,
    input  logic [RA_W-1:0] mem_wb_addr,
    input  logic            mem_is_load,
    input  logic [31:0]     mem_alu_result,
    input  logic            wb_en,
    input  logic [RA_W-1:0] wb_addr,
    input  logic [31:0]     wb_data,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic [3:0]      alu_oper,
    output logic            alu_sign,
    output logic            ex_valid,
    output logic [31:0]     ex_pc,
    output logic            ex_wb_en,
    output logic [RA_W-1:0] ex_wb_addr,
    output logic            ex_mem_r,
    output logic            ex_mem_w,
    output logic [31:0]     ex_store_data,
    output logic            load_use_stall
);

    logic [RA_W-1:0] ex_rs_addr;
    logic [RA_W-1:0] ex_rt_addr;
    logic [31:0]     ex_rs_val;
    logic [31:0]     ex_rt_val;
    logic [31:0]     ex_imm;
    logic [4:0]      ex_shamt;
    sel_t            ex_a_sel;
    sel_t            ex_b_sel;

    logic [31:0]     fwd_rs;
    logic [31:0]     fwd_rt;
    logic [31:0]     id_rs_val;
    logic [31:0]     id_rt_val;

    // The register file is written at the end of WB, so a read in ID can miss
    // a value being written this same cycle; pick it up directly.
    assign id_rs_val = (wb_en && (wb_addr != '0) && (wb_addr == id_rs_addr)) ? wb_data : id_rs_data;
    assign id_rt_val = (wb_en && (wb_addr != '0) && (wb_addr == id_rt_addr)) ? wb_data : id_rt_data;

    assign load_use_stall = !ex_stall && ex_valid && ex_mem_r && (ex_wb_addr != '0) && id_valid &&
                            ((ex_wb_addr == id_rs_addr) || (ex_wb_addr == id_rt_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_rs_addr <= '0;
            ex_rt_addr <= '0;
            ex_rs_val  <= '0;
            ex_rt_val  <= '0;
            ex_imm     <= '0;
            ex_shamt   <= '0;
            alu_oper   <= BUBBLE_OPER;
            alu_sign   <= 1'b0;
            ex_a_sel   <= A_RS;
            ex_b_sel   <= B_RT;
            ex_wb_en   <= 1'b0;
            ex_wb_addr <= '0;
            ex_mem_r   <= 1'b0;
            ex_mem_w   <= 1'b0;
        end else if (ex_stall) begin
            // Producers keep retiring while EX is frozen; absorb their results
            // now so they are still visible when the stall releases.
            ex_rs_val <= fwd_rs;
            ex_rt_val <= fwd_rt;
        end else if (id_flush || load_use_stall) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_rs_addr <= '0;
            ex_rt_addr <= '0;
            ex_rs_val  <= '0;
            ex_rt_val  <= '0;
            ex_imm     <= '0;
            ex_shamt   <= '0;
            alu_oper   <= BUBBLE_OPER;
            alu_sign   <= 1'b0;
            ex_a_sel   <= A_RS;
            ex_b_sel   <= B_RT;
            ex_wb_en   <= 1'b0;
            ex_wb_addr <= '0;
            ex_mem_r   <= 1'b0;
            ex_mem_w   <= 1'b0;
        end else begin
            ex_valid   <= id_valid;
            ex_pc      <= id_pc;
            ex_rs_addr <= id_rs_addr;
            ex_rt_addr <= id_rt_addr;
            ex_rs_val  <= id_rs_val;
            ex_rt_val  <= id_rt_val;
            ex_imm     <= id_imm;
            ex_shamt   <= id_shamt;
            alu_oper   <= id_alu_oper;
            alu_sign   <= id_alu_sign;
            ex_a_sel   <= id_a_sel;
            ex_b_sel   <= id_b_sel;
            ex_wb_en   <= id_wb_en;
            ex_wb_addr <= id_wb_addr;
            ex_mem_r   <= id_mem_r;
            ex_mem_w   <= id_mem_w;
        end
    end

    fwd_mux #(.RA_W(RA_W)) u_fwd_rs (
        .addr           (ex_rs_addr),
        .reg_val        (ex_rs_val),
        .mem_wb_en      (mem_wb_en),
        .mem_is_load    (mem_is_load),
        .mem_wb_addr    (mem_wb_addr),
        .mem_alu_result (mem_alu_result),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .val            (fwd_rs)
    );

    fwd_mux #(.RA_W(RA_W)) u_fwd_rt (
        .addr           (ex_rt_addr),
        .reg_val        (ex_rt_val),
        .mem_wb_en      (mem_wb_en),
        .mem_is_load    (mem_is_load),
        .mem_wb_addr    (mem_wb_addr),
        .mem_alu_result (mem_alu_result),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .val            (fwd_rt)
    );

    always_comb begin
        alu_a = '0;
        case (ex_a_sel)
            A_RS:    alu_a = fwd_rs;
            A_SHAMT: alu_a = {27'h0, ex_shamt};
            A_PC:    alu_a = ex_pc;
            default: alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (ex_b_sel)
            B_RT:    alu_b = fwd_rt;
            B_IMM:   alu_b = ex_imm;
            B_EIGHT: alu_b = 32'd8;
            default: alu_b = '0;
        endcase
    end

    assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: a table of single-instruction
// vectors for the operand mux and forwarding priority, followed by directed
// multi-cycle sequences (reset, back-to-back RAW, load-use, stall, flush).
module tb_ex_operand_stage;
    import ex_operand_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_stall, id_flush, id_valid;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs_addr, id_rt_addr, id_shamt, id_wb_addr;
    logic [3:0]  id_alu_oper;
    logic        id_alu_sign;
    logic [1:0]  id_a_sel, id_b_sel;
    logic        id_wb_en, id_mem_r, id_mem_w;
    logic        mem_wb_en, mem_is_load;
    logic [4:0]  mem_wb_addr;
    logic [31:0] mem_alu_result;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
    logic [3:0]  alu_oper;
    logic        alu_sign, ex_valid, ex_wb_en, ex_mem_r, ex_mem_w, load_use_stall;
    logic [4:0]  ex_wb_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_operand_stage #(.RA_W(5), .BUBBLE_OPER(EXE_ALU_ADD)) dut (
        .clk(clk), .rst(rst), .ex_stall(ex_stall), .id_flush(id_flush),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt),
        .id_alu_oper(id_alu_oper), .id_alu_sign(id_alu_sign),
        .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
        .id_wb_en(id_wb_en), .id_wb_addr(id_wb_addr),
        .id_mem_r(id_mem_r), .id_mem_w(id_mem_w),
        .mem_wb_en(mem_wb_en), .mem_wb_addr(mem_wb_addr),
        .mem_is_load(mem_is_load), .mem_alu_result(mem_alu_result),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper), .alu_sign(alu_sign),
        .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_wb_en(ex_wb_en), .ex_wb_addr(ex_wb_addr),
        .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w),
        .ex_store_data(ex_store_data), .load_use_stall(load_use_stall)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs, rt;
        logic [31:0] rs_d, rt_d, imm;
        logic [4:0]  shamt;
        logic [3:0]  oper;
        logic        sign;
        logic [1:0]  a_sel, b_sel;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic        mem_r, mem_w;
    } id_t;

    typedef struct {
        id_t         id;
        logic        me;
        logic [4:0]  ma;
        logic        ml;
        logic [31:0] mr;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] ea, eb, es;
        logic [3:0]  eo;
        logic        esg;
    } vec_t;

    function automatic id_t mk(input logic valid, input logic [31:0] pc,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [31:0] rs_d, input logic [31:0] rt_d,
                               input logic [31:0] imm, input logic [4:0] shamt,
                               input logic [3:0] oper, input logic sign,
                               input logic [1:0] a_sel, input logic [1:0] b_sel,
                               input logic wbe, input logic [4:0] wba,
                               input logic mr, input logic mw);
        id_t r;
        r.valid = valid; r.pc = pc; r.rs = rs; r.rt = rt;
        r.rs_d = rs_d; r.rt_d = rt_d; r.imm = imm; r.shamt = shamt;
        r.oper = oper; r.sign = sign; r.a_sel = a_sel; r.b_sel = b_sel;
        r.wb_en = wbe; r.wb_addr = wba; r.mem_r = mr; r.mem_w = mw;
        return r;
    endfunction

    task automatic drive_id(input id_t i);
        id_valid = i.valid; id_pc = i.pc;
        id_rs_addr = i.rs; id_rt_addr = i.rt;
        id_rs_data = i.rs_d; id_rt_data = i.rt_d;
        id_imm = i.imm; id_shamt = i.shamt;
        id_alu_oper = i.oper; id_alu_sign = i.sign;
        id_a_sel = i.a_sel; id_b_sel = i.b_sel;
        id_wb_en = i.wb_en; id_wb_addr = i.wb_addr;
        id_mem_r = i.mem_r; id_mem_w = i.mem_w;
    endtask

    task automatic set_fwd(input logic me, input logic [4:0] ma, input logic ml,
                           input logic [31:0] mr, input logic we,
                           input logic [4:0] wa, input logic [31:0] wd);
        mem_wb_en = me; mem_wb_addr = ma; mem_is_load = ml; mem_alu_result = mr;
        wb_en = we; wb_addr = wa; wb_data = wd;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs[11];
    id_t  nop, addu, subu, lw, use_ld, cons, other, st, byp;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, EXE_ALU_ADD, 0, A_RS, B_RT, 0, 0, 0, 0);
        rst = 1'b1; ex_stall = 1'b0; id_flush = 1'b0;
        drive_id(nop);
        set_fwd(0, 0, 0, 0, 0, 0, 0);

        // vector table: {ID instr, MEM fwd, WB fwd, expected a, b, store, oper, sign}
        vecs[0]  = '{mk(1, 32'h40, 1, 2, 5, 7, 0, 0, EXE_ALU_ADD, 0, A_RS, B_RT, 1, 3, 0, 0),
                     0, 0, 0, 0, 0, 0, 0, 5, 7, 7, EXE_ALU_ADD, 0};
        vecs[1]  = '{mk(1, 32'h44, 3, 1, 32'hdead, 5, 0, 0, EXE_ALU_SUB, 0, A_RS, B_RT, 1, 4, 0, 0),
                     1, 3, 0, 12, 0, 0, 0, 12, 5, 5, EXE_ALU_SUB, 0};
        vecs[2]  = '{mk(1, 32'h48, 3, 4, 0, 1, 0, 0, EXE_ALU_SUB, 1, A_RS, B_RT, 1, 4, 0, 0),
                     1, 3, 0, 12, 1, 3, 99, 12, 1, 1, EXE_ALU_SUB, 1};
        vecs[3]  = '{mk(1, 32'h4c, 3, 2, 32'h11, 32'h22, 0, 0, EXE_ALU_OR, 0, A_RS, B_RT, 1, 8, 0, 0),
                     1, 3, 1, 32'h55, 0, 0, 0, 32'h11, 32'h22, 32'h22, EXE_ALU_OR, 0};
        vecs[4]  = '{mk(1, 32'h50, 6, 6, 0, 0, 0, 0, EXE_ALU_ADD, 0, A_RS, B_RT, 1, 8, 0, 0),
                     1, 3, 1, 32'h55, 1, 6, 32'h77, 32'h77, 32'h77, 32'h77, EXE_ALU_ADD, 0};
        vecs[5]  = '{mk(1, 32'h54, 0, 0, 32'h1234, 32'h5678, 0, 0, EXE_ALU_ADD, 0, A_RS, B_RT, 1, 8, 0, 0),
                     1, 0, 0, 32'h99, 1, 0, 32'h88, 0, 0, 0, EXE_ALU_ADD, 0};
        vecs[6]  = '{mk(1, 32'h58, 0, 1, 0, 3, 0, 4, EXE_ALU_SLL, 0, A_SHAMT, B_RT, 1, 2, 0, 0),
                     0, 0, 0, 0, 0, 0, 0, 4, 3, 3, EXE_ALU_SLL, 0};
        vecs[7]  = '{mk(1, 32'h100, 0, 0, 0, 0, 0, 0, EXE_ALU_ADD, 0, A_PC, B_EIGHT, 1, 31, 0, 0),
                     0, 0, 0, 0, 0, 0, 0, 32'h100, 8, 0, EXE_ALU_ADD, 0};
        vecs[8]  = '{mk(1, 32'h5c, 1, 2, 10, 32'h33, 32'hfffffff0, 0, EXE_ALU_ADD, 1, A_RS, B_IMM, 1, 2, 0, 0),
                     0, 0, 0, 0, 0, 0, 0, 10, 32'hfffffff0, 32'h33, EXE_ALU_ADD, 1};
        vecs[9]  = '{mk(1, 32'h60, 1, 2, 10, 32'h42, 32'h77, 9, EXE_ALU_XOR, 0, 2'd3, 2'd3, 1, 2, 0, 0),
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h42, EXE_ALU_XOR, 0};
        vecs[10] = '{mk(1, 32'h64, 5, 6, 1, 2, 0, 0, EXE_ALU_ADD, 0, A_RS, B_RT, 1, 7, 0, 0),
                     1, 6, 0, 32'ha, 1, 5, 32'hb, 32'hb, 32'ha, 32'ha, EXE_ALU_ADD, 0};

        @(negedge clk);
        check("reset_alu_oper", {28'h0, alu_oper}, {28'h0, EXE_ALU_ADD});
        check("reset_alu_a", alu_a, 0);
        check("reset_valid", {31'h0, ex_valid}, 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive_id(vecs[i].id);
            set_fwd(vecs[i].me, vecs[i].ma, vecs[i].ml, vecs[i].mr, vecs[i].we, vecs[i].wa, vecs[i].wd);
            step();
            check($sformatf("vec%0d_alu_a", i), alu_a, vecs[i].ea);
            check($sformatf("vec%0d_alu_b", i), alu_b, vecs[i].eb);
            check($sformatf("vec%0d_store", i), ex_store_data, vecs[i].es);
            check($sformatf("vec%0d_oper", i), {28'h0, alu_oper}, {28'h0, vecs[i].eo});
            check($sformatf("vec%0d_sign", i), {31'h0, alu_sign}, {31'h0, vecs[i].esg});
            check($sformatf("vec%0d_valid", i), {31'h0, ex_valid}, 1);
        end

        // asynchronous reset mid-cycle, during a stall
        set_fwd(0, 0, 0, 0, 0, 0, 0);
        drive_id(mk(1, 32'h200, 1, 2, 5, 7, 3, 2, EXE_ALU_SUB, 1, A_PC, B_EIGHT, 1, 9, 1, 1));
        step();
        check("pre_reset_valid", {31'h0, ex_valid}, 1);
        drive_id(nop);
        ex_stall = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("areset_valid", {31'h0, ex_valid}, 0);
        check("areset_alu_a", alu_a, 0);
        check("areset_alu_b", alu_b, 0);
        check("areset_oper", {28'h0, alu_oper}, {28'h0, EXE_ALU_ADD});
        check("areset_sign", {31'h0, alu_sign}, 0);
        check("areset_pc", ex_pc, 0);
        check("areset_ctl", {28'h0, ex_wb_en, ex_mem_r, ex_mem_w, load_use_stall}, 0);
        #1 rst = 1'b0;
        ex_stall = 1'b0;
        @(negedge clk);

        // addu $3,$1,$2 ; subu $4,$3,$1 (forward from MEM)
        addu = mk(1, 32'h10, 1, 2, 5, 7, 0, 0, EXE_ALU_ADD, 0, A_RS, B_RT, 1, 3, 0, 0);
        subu = mk(1, 32'h14, 3, 1, 0, 5, 0, 0, EXE_ALU_SUB, 0, A_RS, B_RT, 1, 4, 0, 0);
        drive_id(addu);
        step();
        check("raw_addu_a", alu_a, 5);
        check("raw_addu_b", alu_b, 7);
        drive_id(subu);
        step();
        set_fwd(1, 3, 0, 5 + 7, 0, 0, 0);
        #1;
        check("raw_mem_a", alu_a, 12);
        check("raw_mem_b", alu_b, 5);
        check("raw_mem_oper", {28'h0, alu_oper}, {28'h0, EXE_ALU_SUB});

        // same pair with a nop between: forward from WB
        set_fwd(0, 0, 0, 0, 0, 0, 0);
        drive_id(addu);
        step();
        drive_id(nop);
        step();
        set_fwd(1, 3, 0, 12, 0, 0, 0);
        drive_id(subu);
        step();
        set_fwd(0, 0, 0, 0, 1, 3, 12);
        #1;
        check("raw_wb_a", alu_a, 12);

        // lw $5 ; addu $6,$5,$5
        set_fwd(0, 0, 0, 0, 0, 0, 0);
        lw     = mk(1, 32'h20, 1, 0, 5, 0, 4, 0, EXE_ALU_ADD, 0, A_RS, B_IMM, 1, 5, 1, 0);
        use_ld = mk(1, 32'h24, 5, 5, 0, 0, 0, 0, EXE_ALU_ADD, 0, A_RS, B_RT, 1, 6, 0, 0);
        drive_id(lw);
        step();
        check("lu_no_self_stall", {31'h0, load_use_stall}, 0);
        drive_id(use_ld);
        #1;
        check("lu_stall_high", {31'h0, load_use_stall}, 1);
        step();
        set_fwd(1, 5, 1, 32'h999, 0, 0, 0);
        #1;
        check("lu_bubble_valid", {31'h0, ex_valid}, 0);
        check("lu_bubble_wb_en", {31'h0, ex_wb_en}, 0);
        check("lu_stall_drop", {31'h0, load_use_stall}, 0);
        check("lu_bubble_a", alu_a, 0);
        step();
        set_fwd(0, 0, 0, 0, 1, 5, 32'hcafe);
        #1;
        check("lu_use_valid", {31'h0, ex_valid}, 1);
        check("lu_use_pc", ex_pc, 32'h24);
        check("lu_use_a", alu_a, 32'hcafe);
        check("lu_use_b", alu_b, 32'hcafe);

        // load-use is masked while EX is stalled
        set_fwd(0, 0, 0, 0, 0, 0, 0);
        drive_id(lw);
        step();
        ex_stall = 1'b1;
        drive_id(use_ld);
        #1;
        check("lu_masked", {31'h0, load_use_stall}, 0);
        ex_stall = 1'b0;
        #1;
        check("lu_unmasked", {31'h0, load_use_stall}, 1);
        drive_id(nop);
        step();

        // stall for 3 cycles while the rs producer goes MEM -> WB -> retired
        cons  = mk(1, 32'h30, 3, 2, 0, 7, 0, 0, EXE_ALU_ADD, 0, A_RS, B_RT, 1, 7, 0, 0);
        other = mk(1, 32'h34, 1, 1, 32'haa, 32'hbb, 0, 0, EXE_ALU_SUB, 1, A_PC, B_EIGHT, 0, 0, 0, 1);
        drive_id(cons);
        step();
        set_fwd(1, 3, 0, 32'h1111, 0, 0, 0);
        ex_stall = 1'b1;
        id_flush = 1'b1;
        drive_id(other);
        #1;
        check("stall_mem_a", alu_a, 32'h1111);
        step();
        set_fwd(0, 0, 0, 0, 1, 3, 32'h1111);
        #1;
        check("stall_wb_a", alu_a, 32'h1111);
        step();
        set_fwd(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("stall_retired_a", alu_a, 32'h1111);
        step();
        ex_stall = 1'b0;
        id_flush = 1'b0;
        #1;
        check("stall_release_a", alu_a, 32'h1111);
        check("stall_release_b", alu_b, 7);
        check("stall_hold_pc", ex_pc, 32'h30);
        check("stall_hold_wb_addr", {27'h0, ex_wb_addr}, 7);
        check("stall_flush_ignored", {30'h0, ex_valid, ex_mem_w}, 32'h2);
        check("stall_hold_oper", {28'h0, alu_oper}, {28'h0, EXE_ALU_ADD});

        // flush without stall inserts a bubble, then a store is captured
        st = mk(1, 32'h40, 1, 2, 5, 7, 8, 0, EXE_ALU_ADD, 0, A_RS, B_IMM, 0, 0, 0, 1);
        drive_id(st);
        id_flush = 1'b1;
        step();
        id_flush = 1'b0;
        #1;
        check("flush_valid", {31'h0, ex_valid}, 0);
        check("flush_wb_en", {31'h0, ex_wb_en}, 0);
        check("flush_mem_w", {31'h0, ex_mem_w}, 0);
        step();
        check("store_mem_w", {31'h0, ex_mem_w}, 1);
        check("store_b", alu_b, 8);
        check("store_data", ex_store_data, 7);

        // ID bypass: WB write in the capture cycle is latched
        byp = mk(1, 32'h50, 9, 0, 0, 0, 0, 0, EXE_ALU_ADD, 0, A_RS, B_RT, 1, 10, 0, 0);
        set_fwd(0, 0, 0, 0, 1, 9, 32'hbeef);
        drive_id(byp);
        step();
        set_fwd(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("id_bypass_a", alu_a, 32'hbeef);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
